// File: rtl/pipeline_ctrl_pkg.sv
// Shared pipeline control types: ctrl_t bundle, stage indices and controller state encoding.
package pipeline_types;

    localparam int PAUSE_W    = 7;
    localparam int STAGE_PC   = 0;
    localparam int STAGE_IF   = 1;
    localparam int STAGE_ID   = 2;
    localparam int STAGE_DISP = 3;
    localparam int STAGE_EX   = 4;
    localparam int STAGE_MEM  = 5;
    localparam int STAGE_WB   = 6;

    // Every stage except wb holds so the wb register can drain while sleeping.
    localparam logic [PAUSE_W-1:0] IDLE_PAUSE = 7'b0111111;

    typedef struct packed {
        logic [PAUSE_W-1:0] pause;
        logic               exception_flush;
    } ctrl_t;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_IDLE  = 2'd2
    } ctrl_state_t;

    function automatic logic [2:0] highest_req(input logic [PAUSE_W-1:0] req);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < PAUSE_W; i++) begin
            if (req[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_pause_encoder.sv
// Turns per-stage stall requests into a contiguous prefix pause vector: the highest
// requester pauses itself and every stage upstream of it. Purely combinational.
module pause_encoder
    import pipeline_types::*;
(
    input  logic [PAUSE_W-1:0] stall_req,
    output logic [PAUSE_W-1:0] pause
);

    logic acc;

    always_comb begin
        pause = '0;
        acc   = 1'b0;
        for (int i = PAUSE_W - 1; i >= 0; i--) begin
            acc      = acc | stall_req[i];
            pause[i] = acc;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central pipeline controller: stall merge, exception/ertn flush sequencing, IDLE sleep, stall watchdog.
// Optional per-stage stall and flush performance counters under `STALL_PERF_EN.
module pipeline_ctrl
    import pipeline_types::*;
#(
    parameter int WATCHDOG_W = 16,
    parameter int PERF_W     = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [PAUSE_W-1:0]             stall_req,
    input  logic                           exception_req,
    input  logic [31:0]                    exception_pc,
    input  logic                           ertn_req,
    input  logic [31:0]                    ertn_pc,
    input  logic                           idle_req,
    input  logic                           interrupt_pending,
    output ctrl_t                          ctrl,
    output logic [31:0]                    flush_pc,
    output logic                           idle_state,
    output logic                           watchdog_timeout
`ifdef STALL_PERF_EN
    ,
    output logic [PAUSE_W-1:0][PERF_W-1:0] perf_stall_cnt,
    output logic [PERF_W-1:0]              perf_flush_cnt
`endif
);

    ctrl_state_t         state_q;
    logic                flush_q;
    logic                idle_q;
    logic [31:0]         flush_pc_q;
    logic [PAUSE_W-1:0]  enc_pause;
    logic [PAUSE_W-1:0]  pause;
    logic [WATCHDOG_W-1:0] wd_cnt_q, wd_cnt_d;
    logic                wd_to_q, wd_to_d;

    pause_encoder u_pause_encoder (
        .stall_req (stall_req),
        .pause     (enc_pause)
    );

    // Only RUN follows the stall requests; the pause path stays combinational.
    always_comb begin
        pause = '0;
        case (state_q)
            ST_RUN:   pause = enc_pause;
            ST_FLUSH: pause = '0;
            ST_IDLE:  pause = IDLE_PAUSE;
            default:  pause = '0;
        endcase
    end

    assign ctrl.pause           = pause;
    assign ctrl.exception_flush = flush_q;
    assign flush_pc             = flush_pc_q;
    assign idle_state           = idle_q;
    assign watchdog_timeout     = wd_to_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            flush_q    <= 1'b0;
            idle_q     <= 1'b0;
            flush_pc_q <= '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (exception_req) begin
                        state_q    <= ST_FLUSH;
                        flush_q    <= 1'b1;
                        flush_pc_q <= exception_pc;
                    end else if (ertn_req) begin
                        state_q    <= ST_FLUSH;
                        flush_q    <= 1'b1;
                        flush_pc_q <= ertn_pc;
                    end else if (idle_req) begin
                        state_q <= ST_IDLE;
                        idle_q  <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    state_q <= ST_RUN;
                    flush_q <= 1'b0;
                end
                ST_IDLE: begin
                    if (exception_req) begin
                        state_q    <= ST_FLUSH;
                        flush_q    <= 1'b1;
                        idle_q     <= 1'b0;
                        flush_pc_q <= exception_pc;
                    end else if (interrupt_pending) begin
                        state_q <= ST_RUN;
                        idle_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_RUN;
                    flush_q <= 1'b0;
                    idle_q  <= 1'b0;
                end
            endcase
        end
    end

    // Counts consecutive RUN cycles with the front end held; saturates rather than wraps.
    always_comb begin
        wd_cnt_d = '0;
        if (state_q == ST_RUN && pause[STAGE_PC]) begin
            wd_cnt_d = (&wd_cnt_q) ? wd_cnt_q : wd_cnt_q + WATCHDOG_W'(1);
        end
        wd_to_d = wd_to_q | (&wd_cnt_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt_q <= '0;
            wd_to_q  <= 1'b0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            wd_to_q  <= wd_to_d;
        end
    end

`ifdef STALL_PERF_EN
    logic [PAUSE_W-1:0][PERF_W-1:0] perf_stall_q;
    logic [PERF_W-1:0]              perf_flush_q;
    logic [2:0]                     origin;

    assign origin         = highest_req(stall_req);
    assign perf_stall_cnt = perf_stall_q;
    assign perf_flush_cnt = perf_flush_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (state_q == ST_RUN && |stall_req) begin
                perf_stall_q[origin] <= perf_stall_q[origin] + PERF_W'(1);
            end
            if (state_q == ST_FLUSH) begin
                perf_flush_q <= perf_flush_q + PERF_W'(1);
            end
        end
    end
`endif

endmodule
